// File: rtl/subinst_sched_pkg.sv
// Shared types and helpers for the sub-instance round-robin scheduler.
package subinst_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StGap
   } sched_state_e;

   localparam int unsigned N_REQ_DEF = 5;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of e at or above ptr, wrapping.
module rr_pick
   import subinst_sched_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] e,
   input  logic [IW-1:0]    ptr,
   output logic             valid,
   output logic [IW-1:0]    idx
);

   always_comb begin
      int unsigned s;
      valid = 1'b0;
      idx   = '0;
      s     = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         s = 32'(ptr) + i;
         if (s >= N_REQ) begin
            s = s - N_REQ;
         end
         if (!valid && e[IW'(s)]) begin
            valid = 1'b1;
            idx   = IW'(s);
         end
      end
   end

endmodule

// File: rtl/subinst_rr_scheduler.sv
// Round-robin scheduler granting one child instance at a time onto a shared slot,
// released by done or by a programmable busy-cycle timeout.
module subinst_rr_scheduler
   import subinst_sched_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned TMO_W  = 8,
   parameter int unsigned STAT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           en_mask,
   input  logic [N_REQ-1:0]           done,
   input  logic [TMO_W-1:0]           cfg_timeout,
   output logic [N_REQ-1:0]           grant,
   output logic [idx_w(N_REQ)-1:0]    grant_idx,
   output logic                       busy,
   output logic                       timeout_err,
   output logic [idx_w(N_REQ)-1:0]    timeout_idx,
   output logic [STAT_W-1:0]          done_cnt,
   output logic [STAT_W-1:0]          tmo_cnt
);

   localparam int unsigned IW = idx_w(N_REQ);

   sched_state_e      state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic [TMO_W-1:0]  cnt_q, cnt_d;
   logic              terr_q, terr_d;
   logic [IW-1:0]     tidx_q, tidx_d;
   logic [STAT_W-1:0] done_cnt_q, done_cnt_d;
   logic [STAT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic              pick_valid;
   logic [IW-1:0]     pick_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .e     (req & en_mask),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      cnt_d      = cnt_q;
      terr_d     = 1'b0;
      tidx_d     = tidx_q;
      done_cnt_d = done_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;

      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = StBusy;
               gidx_d  = pick_idx;
               grant_d = N_REQ'(1) << pick_idx;
               cnt_d   = '0;
            end
         end
         StBusy: begin
            cnt_d = cnt_q + TMO_W'(1);
            // done takes priority over a timeout landing on the same cycle
            if (done[gidx_q]) begin
               state_d = StGap;
               grant_d = '0;
               if (done_cnt_q != '1) begin
                  done_cnt_d = done_cnt_q + STAT_W'(1);
               end
            end else if ((cfg_timeout != '0) && (cnt_q == cfg_timeout - TMO_W'(1))) begin
               state_d = StGap;
               grant_d = '0;
               terr_d  = 1'b1;
               tidx_d  = gidx_q;
               if (tmo_cnt_q != '1) begin
                  tmo_cnt_d = tmo_cnt_q + STAT_W'(1);
               end
            end
         end
         StGap: begin
            state_d = StIdle;
            ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         grant_q    <= '0;
         gidx_q     <= '0;
         cnt_q      <= '0;
         terr_q     <= 1'b0;
         tidx_q     <= '0;
         done_cnt_q <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         cnt_q      <= cnt_d;
         terr_q     <= terr_d;
         tidx_q     <= tidx_d;
         done_cnt_q <= done_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = gidx_q;
   assign busy        = (state_q == StBusy);
   assign timeout_err = terr_q;
   assign timeout_idx = tidx_q;
   assign done_cnt    = done_cnt_q;
   assign tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Bench for subinst_rr_scheduler: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_subinst_rr_scheduler;

   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] req = '0;
   logic [4:0] en_mask = 5'b11111;
   logic [4:0] done = '0;
   logic [7:0] cfg = '0;

   logic [4:0] grant, grant_s;
   logic [2:0] grant_idx, grant_idx_s, timeout_idx, timeout_idx_s;
   logic       busy, busy_s, timeout_err, timeout_err_s;
   logic [7:0] done_cnt, tmo_cnt;
   logic [1:0] done_cnt_s, tmo_cnt_s;

   int vectors = 0;
   int miscompares = 0;

   subinst_rr_scheduler #(.N_REQ(5), .TMO_W(8), .STAT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .en_mask     (en_mask),
      .done        (done),
      .cfg_timeout (cfg),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_idx (timeout_idx),
      .done_cnt    (done_cnt),
      .tmo_cnt     (tmo_cnt)
   );

   subinst_rr_scheduler #(.N_REQ(5), .TMO_W(8), .STAT_W(2)) dut_s (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .en_mask     (en_mask),
      .done        (done),
      .cfg_timeout (cfg),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .busy        (busy_s),
      .timeout_err (timeout_err_s),
      .timeout_idx (timeout_idx_s),
      .done_cnt    (done_cnt_s),
      .tmo_cnt     (tmo_cnt_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int n, input int w);
      int m;
      m = (1 << w) - 1;
      return (n > m) ? m : n;
   endfunction

   function automatic bit bit_of(input logic [4:0] v, input int i);
      return v[3'(i)];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs as seen by the DUT at the most recent rising edge.
   logic [4:0] s_req, s_en, s_done;
   int         s_cfg;
   logic       s_rst;
   bit         s_valid = 1'b0;

   initial forever begin
      @(posedge clk);
      s_req   = req;
      s_en    = en_mask;
      s_done  = done;
      s_cfg   = int'(cfg);
      s_rst   = rst_n;
      s_valid = 1'b1;
   end

   // Model: owner is the held instance (-1 when none); gap marks the dead cycle after a release.
   int m_owner = -1, m_gap = 0, m_ptr = 0, m_idx = 0, m_age = 0;
   int m_terr = 0, m_tidx = 0, n_done = 0, n_tmo = 0;

   task automatic model_step();
      int j;
      if (!s_rst) begin
         m_owner = -1; m_gap = 0; m_ptr = 0; m_idx = 0; m_age = 0;
         m_terr = 0; m_tidx = 0; n_done = 0; n_tmo = 0;
      end else begin
         m_terr = 0;
         if (m_gap != 0) begin
            m_gap = 0;
            m_ptr = (m_idx + 1) % N;
         end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (m_owner < 0 && bit_of(s_req, j) && bit_of(s_en, j)) m_owner = j;
            end
            if (m_owner >= 0) begin
               m_idx = m_owner;
               m_age = 0;
            end
         end else begin
            if (bit_of(s_done, m_owner)) begin
               n_done++;
               m_owner = -1;
               m_gap = 1;
            end else if (s_cfg != 0 && (m_age % 256) == s_cfg - 1) begin
               m_terr = 1;
               m_tidx = m_owner;
               n_tmo++;
               m_owner = -1;
               m_gap = 1;
            end
            m_age++;
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (s_valid) begin
         model_step();
         chk("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
         chk("grant_idx", int'(grant_idx), m_idx);
         chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
         chk("timeout_err", int'(timeout_err), m_terr);
         chk("timeout_idx", int'(timeout_idx), m_tidx);
         chk("done_cnt", int'(done_cnt), sat(n_done, 8));
         chk("tmo_cnt", int'(tmo_cnt), sat(n_tmo, 8));
         chk("done_cnt_sat2", int'(done_cnt_s), sat(n_done, 2));
         chk("tmo_cnt_sat2", int'(tmo_cnt_s), sat(n_tmo, 2));
      end
   end

   initial begin
      tick(); tick();
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done_cnt", int'(done_cnt), 0);

      // single request, done on the fourth grant cycle
      rst_n = 1'b1; req = 5'b00100; tick();
      chk("t1_grant", int'(grant), 4);
      chk("t1_idx", int'(grant_idx), 2);
      chk("t1_busy", int'(busy), 1);
      tick(); tick(); tick();
      done = 5'b00100; tick(); done = '0;
      chk("t1_release", int'(grant), 0);
      chk("t1_done_cnt", int'(done_cnt), 1);
      req = 5'b11111; tick();
      chk("t1_gap_idle", int'(grant), 0);
      tick();
      chk("t1_ptr3", int'(grant_idx), 3);

      // rotation
      rst_n = 1'b0; tick(); rst_n = 1'b1; req = 5'b11111; tick();
      for (int k = 0; k < 6; k++) begin
         chk("rot_grant", int'(grant), 1 << (k % 5));
         done = 5'(1 << (k % 5)); tick(); done = '0;
         chk("rot_gap", int'(grant), 0);
         tick();
         chk("rot_idle", int'(grant), 0);
         tick();
      end

      // timeout
      rst_n = 1'b0; tick(); rst_n = 1'b1; req = 5'b00010; cfg = 8'd4; tick();
      for (int i = 0; i < 4; i++) begin
         chk("tmo_held", int'(grant), 2);
         chk("tmo_no_err", int'(timeout_err), 0);
         tick();
      end
      chk("tmo_release", int'(grant), 0);
      chk("tmo_err", int'(timeout_err), 1);
      chk("tmo_idx", int'(timeout_idx), 1);
      chk("tmo_cnt", int'(tmo_cnt), 1);
      tick();
      chk("tmo_err_once", int'(timeout_err), 0);
      tick();
      chk("tmo_regrant", int'(grant), 2);
      cfg = '0; done = 5'b00010; tick(); done = '0; req = '0; tick(); tick();

      // masking and done/timeout collision
      rst_n = 1'b0; tick(); rst_n = 1'b1; en_mask = 5'b11101; req = 5'b00010; tick(); tick();
      chk("mask_no_grant", int'(grant), 0);
      req = 5'b00110; cfg = 8'd2; tick();
      chk("mask_grant2", int'(grant), 4);
      tick();
      done = 5'b00100; tick(); done = '0;
      chk("coll_release", int'(grant), 0);
      chk("coll_no_err", int'(timeout_err), 0);
      chk("coll_done_cnt", int'(done_cnt), 1);
      chk("coll_tmo_cnt", int'(tmo_cnt), 0);
      en_mask = 5'b11111; cfg = '0; req = '0; tick(); tick();

      // stray done, then reset mid-grant
      rst_n = 1'b0; tick(); rst_n = 1'b1; req = 5'b00100; tick();
      done = 5'b00100; tick(); done = '0; req = 5'b01000; tick(); tick();
      chk("stray_grant3", int'(grant), 8);
      done = 5'b00001; tick(); done = '0;
      chk("stray_held", int'(grant), 8);
      rst_n = 1'b0; tick();
      chk("midrst_grant", int'(grant), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done_cnt", int'(done_cnt), 0);
      rst_n = 1'b1; req = 5'b11111; tick();
      chk("midrst_ptr0", int'(grant), 1);
      done = 5'b00001; tick(); done = '0; req = '0; tick(); tick();

      // saturation of the 2-bit statistics
      rst_n = 1'b0; tick(); rst_n = 1'b1; req = 5'b00001;
      repeat (5) begin
         tick();
         done = 5'b00001; tick(); done = '0;
         tick();
      end
      chk("sat_done_cnt2", int'(done_cnt_s), 3);
      chk("sat_done_cnt8", int'(done_cnt), 5);

      // randomized traffic
      req = '0;
      repeat (3000) begin
         rst_n   = ($urandom_range(0, 299) != 0);
         req     = 5'($urandom);
         en_mask = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b11111;
         done    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
         if ($urandom_range(0, 19) == 0) cfg = 8'($urandom_range(0, 6));
         tick();
      end
      rst_n = 1'b1; req = '0; done = '0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/subinst_rr_scheduler.md
# subinst_rr_scheduler

Round-robin scheduler that sequences the five leaf instances of a generated sub-hierarchy, such as the `sc8_0`..`sc8_4` children, onto one shared resource slot. It accepts per-instance requests and grants exactly one instance at a time. It holds each grant until that instance reports done or a programmable timeout expires, then rotates priority. It sits in the parent wrapper, between the child instances and the shared resource.

## Interface
Parameters:
- `N_REQ`, default 5: number of requesting child instances (2..8).
- `TMO_W`, default 8: width of the timeout configuration and of the busy-cycle counter.
- `STAT_W`, default 8: width of the saturating statistics counters.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-instance request, level-sensitive.
- `en_mask`  in  N_REQ  per-instance enable; a request is eligible only if `req[i] & en_mask[i]`.
- `done`  in  N_REQ  per-instance completion, single-cycle pulse; only the bit of the granted instance is honoured.
- `cfg_timeout`  in  TMO_W  maximum number of BUSY cycles per grant; 0 disables the timeout.
- `grant`  out  N_REQ  one-hot grant, registered; all-zero when no grant is held.
- `grant_idx`  out  $clog2(N_REQ)  index of the current or last winner.
- `busy`  out  1  high while a grant is held.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.
- `timeout_idx`  out  $clog2(N_REQ)  index of the timed-out instance; updated with `timeout_err`.
- `done_cnt`  out  STAT_W  completions by `done`, saturating.
- `tmo_cnt`  out  STAT_W  completions by timeout, saturating.

## Operation
FSM with states IDLE, BUSY and GAP.
- **IDLE**
  - Eligible set is `E = req & en_mask`.
  - If E≠0: the winner is the first set bit of E searching from `ptr` upward, wrapping N_REQ-1→0. Register `grant_idx`, set `grant` one-hot, clear the cycle counter, go to BUSY.
  - If E=0: stay in IDLE, `grant`=0.
- **BUSY**
  - `grant` and `grant_idx` are held.
  - The counter increments every cycle.
  - `done[grant_idx]`=1: go to GAP, `done_cnt`+1.
  - Else if `cfg_timeout`≠0 and counter==`cfg_timeout`-1: go to GAP, `timeout_err`=1 for one cycle, `timeout_idx`=`grant_idx`, `tmo_cnt`+1.
  - `done` and timeout in the same cycle: `done` wins and no error is raised.
  - `done` bits of non-granted instances are ignored.
  - Dropping `req` or `en_mask` of the granted instance does not revoke the grant.
- **GAP**
  - `grant`=0 for exactly one cycle.
  - `ptr` ← (`grant_idx`+1) mod N_REQ.
  - Go to IDLE.
- `cfg_timeout` is sampled every BUSY cycle. Changing it mid-grant takes effect immediately; a new value ≤ the current count does not fire until the counter wraps.
- Statistics counters saturate at 2^STAT_W-1 and never wrap.

## Timing
- Reset (`rst_n`=0 at an edge) forces the following, regardless of state, including mid-grant:
  - state IDLE, `ptr`=0;
  - `grant`=0, `grant_idx`=0, `busy`=0;
  - `timeout_err`=0, `timeout_idx`=0;
  - `done_cnt`=0, `tmo_cnt`=0.
- Request to grant: eligible `req` present in cycle c (IDLE) → `grant` high in cycle c+1.
- Done to release: `done` in cycle k → `grant` low in k+1 (GAP). Earliest next grant is k+3.
- Timeout: with `cfg_timeout`=T, `grant` is high for exactly T cycles, then low. `timeout_err` is high in the first GAP cycle.
- `busy` equals (state==BUSY); it is registered and aligned with `grant`.
- No combinational path exists from `req`/`done` to `grant`.

## Structure
- Package `subinst_sched_pkg` holds:
  - the state enum `sched_state_e` (IDLE, BUSY, GAP);
  - `N_REQ_DEF`=5;
  - an index-width helper function.
- Sub-module `rr_pick`: combinational rotate-priority picker.
  - Inputs: `E`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Instantiated once.
- Top-level holds the FSM, the counters and the output registers.

## Test plan
- **Single request.** Reset, then `req`=5'b00100, `en_mask`=all ones, `cfg_timeout`=0 → `grant`=5'b00100 one cycle later. Pulse `done[2]` at grant cycle 4 → `grant`=0 next cycle, `done_cnt`=1, `ptr`=3.
- **Rotation.** All five `req` held high, `done` pulsed on the first cycle of each grant → grant order 0,1,2,3,4,0. Each grant is 1 cycle, separated by GAP and IDLE cycles.
- **Timeout.** `cfg_timeout`=4, `req[1]` only, `done` never pulsed → `grant[1]` high exactly 4 cycles, then `timeout_err` pulses once with `timeout_idx`=1 and `tmo_cnt`=1. The instance is regranted after GAP and IDLE.
- **Masking and collision.** `en_mask`=5'b11101 with `req`=5'b00010 → no grant. With `req`=5'b00110 → grant 2. `done[2]` and timeout in the same cycle → `timeout_err` stays 0 and `done_cnt` increments.
- **Reset mid-grant and stray done.** While grant 3 is active, pulse `done[0]` → ignored, grant is held. Assert `rst_n`=0 for one edge → `grant`=0, counters 0, and the next arbitration starts from `ptr`=0.
- **Saturation.** STAT_W=2, five `done` completions → `done_cnt` sticks at 3.
